// File: rtl/hc_codec_pkg.sv
// hc_codec_pkg: shared types and helpers for the hc_codec streaming Hamming codec.
//   - hc_mode_e     : transaction mode (HC_ENC = encode, HC_DEC = decode)
//   - hc_s1_ctrl_t  : control fields registered in pipeline stage S1
//   - hc_s2_ctrl_t  : control fields and error flags registered in stage S2
//   - is_pow2()     : true when a 1-based codeword position holds a check bit
//   - HC_PAR_WD     : 1 when HC_CODEC_SECDED_EN is defined (overall parity bit), else 0
package hc_codec_pkg;

    typedef enum logic {
        HC_ENC = 1'b0,
        HC_DEC = 1'b1
    } hc_mode_e;

    typedef struct packed {
        logic     valid;
        hc_mode_e mode;
    } hc_s1_ctrl_t;

    typedef struct packed {
        logic     valid;
        hc_mode_e mode;
        logic     err_corr;
        logic     err_uncorr;
    } hc_s2_ctrl_t;

`ifdef HC_CODEC_SECDED_EN
    localparam int unsigned HC_PAR_WD = 32'd1;
`else
    localparam int unsigned HC_PAR_WD = 32'd0;
`endif

    // Position p (1-based) is a check position when it is a power of two.
    function automatic logic is_pow2(input int unsigned p);
        return (p != 32'd0) && ((p & (p - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/hc_syn_gen.sv
// hc_syn_gen: combinational Hamming XOR network.
// Returns the XOR of every 1-based position p whose codeword bit is set.
// With the check positions zeroed this yields the check bits to insert;
// applied to a received codeword it yields the syndrome.
// Ports:
//   code [DATA_WD+CHK_WD-1:0]  in   codeword (bit index p-1 holds position p)
//   syn  [CHK_WD-1:0]          out  check bits / syndrome
module hc_syn_gen
    import hc_codec_pkg::*;
#(
    parameter int DATA_WD = 4,
    parameter int CHK_WD  = 3
) (
    input  logic [DATA_WD+CHK_WD-1:0] code,
    output logic [CHK_WD-1:0]         syn
);

    localparam int unsigned N = DATA_WD + CHK_WD;

    // XOR-accumulate the position number of every set bit.
    always_comb begin
        syn = {CHK_WD{1'b0}};
        for (int unsigned p = 1; p <= N; p++) begin
            syn = syn ^ (code[p-1] ? CHK_WD'(p) : {CHK_WD{1'b0}});
        end
    end

endmodule

// File: rtl/hc_codec.sv
// hc_codec: streaming Hamming encoder/decoder with a two-stage valid/ready
// pipeline and saturating error counters.
// Optional feature macro: HC_CODEC_SECDED_EN adds an overall parity bit at
// codeword bit CW-1 so double errors are reported as uncorrectable.
// Ports:
//   clk, reset_n (sync, active-low)
//   i_valid/o_ready       input handshake; o_ready is combinational from i_ready
//   i_mode                0 = encode, 1 = decode
//   i_data [DATA_WD]      data to encode
//   i_code [CW]           codeword to decode
//   o_valid/i_ready       output handshake
//   o_mode, o_data, o_code, o_syndrome, o_err_corr, o_err_uncorr  result fields
//   i_cnt_clr             clears both counters (wins over increment)
//   o_corr_cnt, o_uncorr_cnt [CNT_WD]  saturating error counters
module hc_codec
    import hc_codec_pkg::*;
#(
    parameter  int          DATA_WD = 4,
    parameter  int          CHK_WD  = 3,
    parameter  int          CNT_WD  = 8,
    localparam int unsigned N       = DATA_WD + CHK_WD,
    localparam int unsigned CW      = N + HC_PAR_WD
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_mode,
    input  logic [DATA_WD-1:0] i_data,
    input  logic [CW-1:0]      i_code,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_mode,
    output logic [DATA_WD-1:0] o_data,
    output logic [CW-1:0]      o_code,
    output logic [CHK_WD-1:0]  o_syndrome,
    output logic               o_err_corr,
    output logic               o_err_uncorr,
    input  logic               i_cnt_clr,
    output logic [CNT_WD-1:0]  o_corr_cnt,
    output logic [CNT_WD-1:0]  o_uncorr_cnt
);

    // Pipeline control
    logic s1_adv_s;
    logic s2_adv_s;
    logic out_hs_s;

    // Input-side datapath
    logic [N-1:0]      enc_raw_s;
    logic [CHK_WD-1:0] enc_chk_s;
    logic [CHK_WD-1:0] dec_syn_s;

    // Stage S1
    hc_s1_ctrl_t       s1_ctrl_r;
    logic [CW-1:0]     s1_code_r;   // encode: data scattered, checks zero; decode: received word
    logic [CHK_WD-1:0] s1_syn_r;    // encode: check bits; decode: syndrome
`ifdef HC_CODEC_SECDED_EN
    logic              s1_par_err_r;
`endif

    // Stage S2 next-state
    logic [CW-1:0]      enc_code_s;
    logic [N-1:0]       fixed_s;
    logic [DATA_WD-1:0] dec_data_s;
    logic [31:0]        syn_val_s;
    logic               in_range_s;
    logic               do_flip_s;
    logic               corr_s;
    logic               uncorr_s;
    logic [DATA_WD-1:0] s2_data_nxt_s;
    logic [CW-1:0]      s2_code_nxt_s;
    logic [CHK_WD-1:0]  s2_syn_nxt_s;
    logic               s2_corr_nxt_s;
    logic               s2_uncorr_nxt_s;

    // Stage S2
    hc_s2_ctrl_t        s2_ctrl_r;
    logic [DATA_WD-1:0] s2_data_r;
    logic [CW-1:0]      s2_code_r;
    logic [CHK_WD-1:0]  s2_syn_r;

    // Counters
    logic [CNT_WD-1:0]  corr_cnt_r;
    logic [CNT_WD-1:0]  uncorr_cnt_r;

    assign s2_adv_s = !s2_ctrl_r.valid || i_ready;
    assign s1_adv_s = !s1_ctrl_r.valid || s2_adv_s;
    assign o_ready  = s1_adv_s;
    assign out_hs_s = s2_ctrl_r.valid && i_ready;

    // Scatter data bits into the non-power-of-two positions, checks left at zero.
    always_comb begin
        int unsigned di;
        di        = 32'd0;
        enc_raw_s = {N{1'b0}};
        for (int unsigned p = 1; p <= N; p++) begin
            if (is_pow2(p)) begin
                enc_raw_s[p-1] = 1'b0;
            end else begin
                enc_raw_s[p-1] = i_data[di];
                di++;
            end
        end
    end

    hc_syn_gen #(.DATA_WD(DATA_WD), .CHK_WD(CHK_WD)) u_enc_syn (
        .code (enc_raw_s),
        .syn  (enc_chk_s)
    );

    hc_syn_gen #(.DATA_WD(DATA_WD), .CHK_WD(CHK_WD)) u_dec_syn (
        .code (i_code[N-1:0]),
        .syn  (dec_syn_s)
    );

    // Stage S1: capture the transaction with its check bits or syndrome.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_ctrl_r    <= '0;
            s1_code_r    <= {CW{1'b0}};
            s1_syn_r     <= {CHK_WD{1'b0}};
`ifdef HC_CODEC_SECDED_EN
            s1_par_err_r <= 1'b0;
`endif
        end else if (s1_adv_s) begin
            s1_ctrl_r.valid <= i_valid;
            s1_ctrl_r.mode  <= i_mode ? HC_DEC : HC_ENC;
            if (i_mode) begin
                s1_code_r <= i_code;
                s1_syn_r  <= dec_syn_s;
            end else begin
                s1_code_r <= CW'(enc_raw_s);
                s1_syn_r  <= enc_chk_s;
            end
`ifdef HC_CODEC_SECDED_EN
            // Whole received word XORs to zero when overall parity agrees.
            s1_par_err_r <= ^i_code;
`endif
        end
    end

    // Stage S2 combinational: build the codeword, or classify and correct.
    always_comb begin
        int unsigned di;
        int unsigned k;
        di              = 32'd0;
        k               = 32'd0;
        enc_code_s      = s1_code_r;
        dec_data_s      = {DATA_WD{1'b0}};
        syn_val_s       = 32'(s1_syn_r);
        in_range_s      = (s1_syn_r != {CHK_WD{1'b0}}) && (syn_val_s <= 32'(N));
        do_flip_s       = 1'b0;
        corr_s          = 1'b0;
        uncorr_s        = 1'b0;
        s2_data_nxt_s   = {DATA_WD{1'b0}};
        s2_code_nxt_s   = {CW{1'b0}};
        s2_syn_nxt_s    = {CHK_WD{1'b0}};
        s2_corr_nxt_s   = 1'b0;
        s2_uncorr_nxt_s = 1'b0;

`ifdef HC_CODEC_SECDED_EN
        // s=0 with parity mismatch means only the parity bit itself flipped.
        if (!s1_par_err_r && (s1_syn_r == {CHK_WD{1'b0}})) begin
            corr_s = 1'b0;
        end else if (s1_par_err_r && (s1_syn_r == {CHK_WD{1'b0}})) begin
            corr_s = 1'b1;
        end else if (s1_par_err_r && in_range_s) begin
            corr_s    = 1'b1;
            do_flip_s = 1'b1;
        end else begin
            uncorr_s = 1'b1;
        end
`else
        if (s1_syn_r == {CHK_WD{1'b0}}) begin
            corr_s = 1'b0;
        end else if (in_range_s) begin
            corr_s    = 1'b1;
            do_flip_s = 1'b1;
        end else begin
            uncorr_s = 1'b1;
        end
`endif

        for (int unsigned p = 1; p <= N; p++) begin
            fixed_s[p-1] = s1_code_r[p-1] ^ (do_flip_s && (syn_val_s == p));
        end

        // Check positions take the next check bit; the rest yield data bits.
        for (int unsigned p = 1; p <= N; p++) begin
            if (is_pow2(p)) begin
                enc_code_s[p-1] = s1_syn_r[k];
                k++;
            end else begin
                enc_code_s[p-1] = s1_code_r[p-1];
                dec_data_s[di]  = fixed_s[p-1];
                di++;
            end
        end
`ifdef HC_CODEC_SECDED_EN
        enc_code_s[CW-1] = ^enc_code_s[N-1:0];
`endif

        if (s1_ctrl_r.mode == HC_ENC) begin
            s2_code_nxt_s = enc_code_s;
        end else begin
            s2_data_nxt_s   = dec_data_s;
            s2_syn_nxt_s    = s1_syn_r;
            s2_corr_nxt_s   = corr_s;
            s2_uncorr_nxt_s = uncorr_s;
        end
    end

    // Stage S2: register the result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_ctrl_r <= '0;
            s2_data_r <= {DATA_WD{1'b0}};
            s2_code_r <= {CW{1'b0}};
            s2_syn_r  <= {CHK_WD{1'b0}};
        end else if (s2_adv_s) begin
            s2_ctrl_r.valid <= s1_ctrl_r.valid;
            if (s1_ctrl_r.valid) begin
                s2_ctrl_r.mode       <= s1_ctrl_r.mode;
                s2_ctrl_r.err_corr   <= s2_corr_nxt_s;
                s2_ctrl_r.err_uncorr <= s2_uncorr_nxt_s;
                s2_data_r            <= s2_data_nxt_s;
                s2_code_r            <= s2_code_nxt_s;
                s2_syn_r             <= s2_syn_nxt_s;
            end
        end
    end

    // Saturating error counters; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            corr_cnt_r   <= {CNT_WD{1'b0}};
            uncorr_cnt_r <= {CNT_WD{1'b0}};
        end else if (i_cnt_clr) begin
            corr_cnt_r   <= {CNT_WD{1'b0}};
            uncorr_cnt_r <= {CNT_WD{1'b0}};
        end else begin
            if (out_hs_s && s2_ctrl_r.err_corr && (corr_cnt_r != {CNT_WD{1'b1}})) begin
                corr_cnt_r <= corr_cnt_r + CNT_WD'(1);
            end
            if (out_hs_s && s2_ctrl_r.err_uncorr && (uncorr_cnt_r != {CNT_WD{1'b1}})) begin
                uncorr_cnt_r <= uncorr_cnt_r + CNT_WD'(1);
            end
        end
    end

    assign o_valid      = s2_ctrl_r.valid;
    assign o_mode       = s2_ctrl_r.mode;
    assign o_err_corr   = s2_ctrl_r.err_corr;
    assign o_err_uncorr = s2_ctrl_r.err_uncorr;
    assign o_data       = s2_data_r;
    assign o_code       = s2_code_r;
    assign o_syndrome   = s2_syn_r;
    assign o_corr_cnt   = corr_cnt_r;
    assign o_uncorr_cnt = uncorr_cnt_r;

endmodule
